gpr_file_mp: RTL and testbench
==============================

Name: gpr_file_mp

Overview:
- Parametrised multi-port general-purpose register file with an integrated pending-write scoreboard, for dual- and quad-issue pipeline variants.
- Generalises read-port and write-port counts and register width.
- Adds optional write-to-read bypass, deterministic write-conflict priority and per-register in-flight write counters.
- Sits between decode (reads, busy query, destination issue) and writeback (writes, scoreboard retire).

Parameters:
DATA_W, 32, register width in bits
NUM_REGS, 32, number of architectural registers; register 0 hardwired to zero
NUM_RD, 4, number of read ports
NUM_WR, 2, number of write/retire ports; port index = program order, higher index = younger
BYPASS, 1, 1: same-cycle write data is forwarded to reads; 0: reads see only stored state
CNT_W, 2, width of per-register pending-write counter

Ports:
clk  in  1  clock
rst  in  1  reset; rst, synchronous, active-high; clock clk
rd_addr  in  NUM_RD x $clog2(NUM_REGS)  read addresses
rd_data  out  NUM_RD x DATA_W  read data, combinational
rd_busy  out  NUM_RD  1 = addressed register has a pending write, combinational
wr_en  in  NUM_WR  write enables (writeback)
wr_addr  in  NUM_WR x $clog2(NUM_REGS)  write addresses
wr_data  in  NUM_WR x DATA_W  write data
iss_en  in  NUM_WR  destination issue enables; marks register pending
iss_addr  in  NUM_WR x $clog2(NUM_REGS)  issued destination addresses
flush  in  1  clears all pending counters; register contents kept
sb_err  out  1  sticky: counter overflow or underflow occurred

Behaviour:
- Reset (synchronous, rst=1 at posedge clk): all registers, all counters and sb_err are 0.
- While rst is held, rd_data=0 and rd_busy=0 for every port.
- Reset overrides flush, iss_en and wr_en in the same cycle.
- Read of address 0 always returns 0 with busy=0, regardless of writes or bypass.
- Writes commit at posedge clk when wr_en=1 and wr_addr!=0; write latency is 1 cycle.
- Same-cycle writes to the same address: the highest-index enabled port wins.
- Bypass (BYPASS=1): if any enabled write targets rd_addr (!=0), rd_data = winning port's wr_data in that cycle.
- BYPASS=0: rd_data = stored value; the new value is visible from the next cycle.
- Scoreboard: per-register counter cnt[r], CNT_W bits.
  - Per cycle: cnt_next = cnt + (number of enabled iss ports to r) - (number of enabled wr ports to r).
  - The increment and decrement for the same register in the same cycle net out.
  - Register 0 is never counted.
- rd_busy = (cnt[rd_addr] != 0) using registered counter state.
  - With BYPASS=1, rd_busy is additionally cleared when this cycle's write retires the last pending write (cnt - decrements == 0 and no new issue).
- Overflow: a result above 2^CNT_W-1 saturates to max and sets sb_err.
- Underflow: a result below 0 clamps to 0 and sets sb_err.
- sb_err is cleared only by rst.
- flush=1: all counters become 0 next cycle. Writes in the same cycle still commit their data; iss_en in the same cycle is ignored.
- No handshake stalls: all ports are accepted every cycle.

Decomposition:
- Shared package (existing MIPS definitions package):
  - MipsReg register-index enum, including ZERO
  - default DATA_W/NUM_REGS constants
  - typedef gpr_wr_port_t {en, addr, data}
- Sub-module gpr_pending_counter: one counter slice with inc/dec counts, flush, saturation and error output; instantiated NUM_REGS-1 times.
- Storage and bypass/priority logic stay in gpr_file_mp.

Test Plan:
- Reset then read all 4 ports at addresses 1,5,31,0 -> rd_data=0, rd_busy=0, sb_err=0.
- Write port0 $3<=0x1111_1111 and port1 $3<=0x2222_2222 in the same cycle, read $3 -> bypass cycle and next cycle both return 0x2222_2222; with BYPASS=0 the same-cycle read returns the old value.
- Write port0 $0<=0xDEAD_BEEF -> read $0 returns 0; a following write to $1 is unaffected.
- Issue $7 on both iss ports in one cycle -> cnt=2, rd_busy=1. Retire one write -> still busy. Retire the second -> busy clears, bypass read returns the second write's data.
- Issue $9 and write $9 in the same cycle with cnt=1 -> cnt stays 1, rd_busy=1, data updated.
- Issue $4 four times with CNT_W=2 -> cnt saturates at 3, sb_err=1. flush -> all busy=0, sb_err stays 1 until rst.

Source files
------------

// File: rtl/gpr_file_mp_pkg.sv
// rtl/gpr_file_mp_pkg.sv - MIPS register definitions and register-file defaults.
package gpr_file_mp_pkg;

  localparam int GPR_DATA_W   = 32;
  localparam int GPR_NUM_REGS = 32;

  typedef enum logic [4:0] {
    ZERO, AT, V0, V1, A0, A1, A2, A3,
    T0, T1, T2, T3, T4, T5, T6, T7,
    S0, S1, S2, S3, S4, S5, S6, S7,
    T8, T9, K0, K1, GP, SP, FP, RA
  } MipsReg;

  typedef struct packed {
    logic                  en;
    logic [4:0]            addr;
    logic [GPR_DATA_W-1:0] data;
  } gpr_wr_port_t;

endpackage

// File: rtl/gpr_pending_counter.sv
// rtl/gpr_pending_counter.sv - one pending-write counter slice with saturation and error flag.
module gpr_pending_counter
  import gpr_file_mp_pkg::*;
#(
  parameter int CNT_W = 2,
  parameter int IW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic [IW-1:0]    inc_i,
  input  logic [IW-1:0]    dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             err_o
);

  // One spare sign bit plus headroom for a full burst of increments.
  localparam int SW = CNT_W + IW + 1;
  localparam logic [SW-1:0] MAX_V = SW'((1 << CNT_W) - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SW-1:0]    sum;
  logic             under, over;

  always_comb begin
    sum   = SW'(cnt_q) + SW'(inc_i) - SW'(dec_i);
    under = sum[SW-1];
    over  = !under && (sum > MAX_V);
    if (flush_i)    cnt_d = '0;
    else if (under) cnt_d = '0;
    else if (over)  cnt_d = MAX_V[CNT_W-1:0];
    else            cnt_d = sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign err_o = !flush_i && (under || over);

endmodule

// File: rtl/gpr_file_mp.sv
// rtl/gpr_file_mp.sv - multi-port GPR file with write bypass and pending-write scoreboard.
module gpr_file_mp
  import gpr_file_mp_pkg::*;
#(
  parameter int DATA_W   = GPR_DATA_W,
  parameter int NUM_REGS = GPR_NUM_REGS,
  parameter int NUM_RD   = 4,
  parameter int NUM_WR   = 2,
  parameter int BYPASS   = 1,
  parameter int CNT_W    = 2,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_RD-1:0][AW-1:0]      rd_addr,
  output logic [NUM_RD-1:0][DATA_W-1:0]  rd_data,
  output logic [NUM_RD-1:0]              rd_busy,
  input  logic [NUM_WR-1:0]              wr_en,
  input  logic [NUM_WR-1:0][AW-1:0]      wr_addr,
  input  logic [NUM_WR-1:0][DATA_W-1:0]  wr_data,
  input  logic [NUM_WR-1:0]              iss_en,
  input  logic [NUM_WR-1:0][AW-1:0]      iss_addr,
  input  logic                           flush,
  output logic                           sb_err
);

  localparam int IW = $clog2(NUM_WR + 1);
  localparam logic [AW-1:0] REG_ZERO = AW'(ZERO);

  logic [DATA_W-1:0]               regs_q [NUM_REGS];
  logic [DATA_W-1:0]               regs_d [NUM_REGS];
  logic [NUM_REGS-1:0][IW-1:0]     inc_cnt, dec_cnt;
  logic [NUM_REGS-1:0][CNT_W-1:0]  cnt;
  logic [NUM_REGS-1:0]             cnt_err;
  logic                            sb_err_q;

  // Ascending port loop: the younger (higher-index) write lands last and wins.
  always_comb begin
    regs_d  = regs_q;
    inc_cnt = '0;
    dec_cnt = '0;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en[w] && wr_addr[w] != REG_ZERO) begin
        regs_d[wr_addr[w]]  = wr_data[w];
        dec_cnt[wr_addr[w]] = dec_cnt[wr_addr[w]] + IW'(1);
      end
      if (iss_en[w] && !flush && iss_addr[w] != REG_ZERO)
        inc_cnt[iss_addr[w]] = inc_cnt[iss_addr[w]] + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign cnt[0]     = '0;
  assign cnt_err[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
    gpr_pending_counter #(.CNT_W(CNT_W), .IW(IW)) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .flush_i (flush),
      .inc_i   (inc_cnt[r]),
      .dec_i   (dec_cnt[r]),
      .cnt_o   (cnt[r]),
      .err_o   (cnt_err[r])
    );
  end

  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      rd_data[p] = regs_q[rd_addr[p]];
      rd_busy[p] = cnt[rd_addr[p]] != '0;
      if (BYPASS != 0) begin
        for (int w = 0; w < NUM_WR; w++)
          if (wr_en[w] && wr_addr[w] == rd_addr[p]) rd_data[p] = wr_data[w];
        // This cycle's writes retire every outstanding write and nothing new is issued.
        if (inc_cnt[rd_addr[p]] == '0 && int'(cnt[rd_addr[p]]) == int'(dec_cnt[rd_addr[p]]))
          rd_busy[p] = 1'b0;
      end
      if (rst || rd_addr[p] == REG_ZERO) begin
        rd_data[p] = '0;
        rd_busy[p] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)           sb_err_q <= 1'b0;
    else if (|cnt_err) sb_err_q <= 1'b1;
  end

  assign sb_err = sb_err_q;

endmodule

// File: tb/tb_gpr_file_mp.sv
// tb/tb_gpr_file_mp.sv - self-checking bench for gpr_file_mp with and without bypass.
module tb_gpr_file_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [3:0][4:0]  rd_addr;
  logic [3:0][31:0] rd_data, rd_data_nb;
  logic [3:0]       rd_busy, rd_busy_nb;
  logic [1:0]       wr_en;
  logic [1:0][4:0]  wr_addr;
  logic [1:0][31:0] wr_data;
  logic [1:0]       iss_en;
  logic [1:0][4:0]  iss_addr;
  logic             flush;
  logic             sb_err, sb_err_nb;

  gpr_file_mp dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
    .iss_addr(iss_addr), .flush(flush), .sb_err(sb_err)
  );

  gpr_file_mp #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
    .iss_addr(iss_addr), .flush(flush), .sb_err(sb_err_nb)
  );

  logic [31:0] m_mem [32];
  int          m_cnt [32];
  bit          m_err;
  int          checks = 0;
  int          errors = 0;

  function automatic int n_iss(int r);
    int n = 0;
    for (int w = 0; w < 2; w++) if (iss_en[w] && int'(iss_addr[w]) == r) n++;
    return n;
  endfunction

  function automatic int n_wr(int r);
    int n = 0;
    for (int w = 0; w < 2; w++) if (wr_en[w] && int'(wr_addr[w]) == r) n++;
    return n;
  endfunction

  function automatic logic [31:0] exp_data(int a, bit byp);
    logic [31:0] v;
    if (rst || a == 0) return 32'h0;
    v = m_mem[a];
    if (byp) for (int w = 0; w < 2; w++) if (wr_en[w] && int'(wr_addr[w]) == a) v = wr_data[w];
    return v;
  endfunction

  function automatic bit exp_busy(int a, bit byp);
    int inc;
    if (rst || a == 0) return 1'b0;
    inc = flush ? 0 : n_iss(a);
    if (byp && m_cnt[a] - n_wr(a) == 0 && inc == 0) return 1'b0;
    return m_cnt[a] != 0;
  endfunction

  task automatic idle();
    wr_en = '0; iss_en = '0; flush = 1'b0;
    wr_addr = '0; wr_data = '0; iss_addr = '0;
  endtask

  // Advance the reference model by one clock using the inputs currently applied.
  task automatic step();
    int n;
    if (rst) begin
      for (int r = 0; r < 32; r++) begin m_mem[r] = '0; m_cnt[r] = 0; end
      m_err = 1'b0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (flush) n = 0;
        else n = m_cnt[r] + n_iss(r) - n_wr(r);
        if (n > 3) begin n = 3; m_err = 1'b1; end
        if (n < 0) begin n = 0; m_err = 1'b1; end
        m_cnt[r] = n;
      end
      for (int w = 0; w < 2; w++) if (wr_en[w] && wr_addr[w] != 0) m_mem[wr_addr[w]] = wr_data[w];
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; idle(); step(); rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wr_en = 2'b11; wr_addr = {5'd5, 5'd1}; wr_data = {32'hAAAA_5555, 32'h1234_5678};
    iss_en = 2'b11; iss_addr = {5'd31, 5'd5}; flush = 1'b1;
    rd_addr = {5'd0, 5'd31, 5'd5, 5'd1};
    #1;
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (rd_data[p] !== 32'h0 || rd_busy[p] !== 1'b0 || rd_data_nb[p] !== 32'h0 || rd_busy_nb[p] !== 1'b0) begin
        errors++;
        $display("FAIL reset_held port %0d: data %h/%h busy %b/%b, need 0", p, rd_data[p], rd_data_nb[p], rd_busy[p], rd_busy_nb[p]);
      end
    end
    step();
    rst = 1'b0; idle();
    #1;
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (rd_data[p] !== 32'h0 || rd_busy[p] !== 1'b0 || rd_data_nb[p] !== 32'h0 || rd_busy_nb[p] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state port %0d: data %h/%h busy %b/%b, need 0", p, rd_data[p], rd_data_nb[p], rd_busy[p], rd_busy_nb[p]);
      end
    end
    checks++;
    if (sb_err !== 1'b0 || sb_err_nb !== 1'b0) begin
      errors++; $display("FAIL reset_sb_err: got %b/%b, need 0", sb_err, sb_err_nb);
    end
  endtask

  task automatic test_priority();
    do_reset();
    wr_en = 2'b11; wr_addr = {5'd3, 5'd3}; wr_data = {32'h2222_2222, 32'h1111_1111};
    rd_addr = {5'd0, 5'd0, 5'd0, 5'd3};
    #1;
    checks++;
    if (rd_data[0] !== 32'h2222_2222) begin
      errors++; $display("FAIL prio_bypass: got %h, need 22222222", rd_data[0]);
    end
    checks++;
    if (rd_data_nb[0] !== 32'h0) begin
      errors++; $display("FAIL prio_nobypass_old: got %h, need 00000000", rd_data_nb[0]);
    end
    step(); idle();
    #1;
    checks++;
    if (rd_data[0] !== 32'h2222_2222 || rd_data_nb[0] !== 32'h2222_2222) begin
      errors++; $display("FAIL prio_stored: got %h/%h, need 22222222", rd_data[0], rd_data_nb[0]);
    end
    checks++;
    if (sb_err !== m_err) begin
      errors++; $display("FAIL prio_underflow_err: got %b, need %b", sb_err, m_err);
    end
  endtask

  task automatic test_zero();
    wr_en = 2'b01; wr_addr = '0; wr_data[0] = 32'hDEAD_BEEF;
    rd_addr = '0;
    #1;
    checks++;
    if (rd_data[0] !== 32'h0 || rd_data_nb[0] !== 32'h0 || rd_busy[0] !== 1'b0) begin
      errors++; $display("FAIL zero_write_bypass: got %h/%h busy %b, need 0", rd_data[0], rd_data_nb[0], rd_busy[0]);
    end
    step(); idle();
    wr_en = 2'b10; wr_addr[1] = 5'd1; wr_data[1] = 32'h1234_5678;
    rd_addr = {5'd0, 5'd0, 5'd1, 5'd0};
    #1;
    checks++;
    if (rd_data[0] !== 32'h0 || rd_data_nb[0] !== 32'h0) begin
      errors++; $display("FAIL zero_read: got %h/%h, need 0", rd_data[0], rd_data_nb[0]);
    end
    step(); idle();
    #1;
    checks++;
    if (rd_data[1] !== 32'h1234_5678 || rd_data_nb[1] !== 32'h1234_5678) begin
      errors++; $display("FAIL zero_then_r1: got %h/%h, need 12345678", rd_data[1], rd_data_nb[1]);
    end
  endtask

  task automatic test_scoreboard();
    do_reset();
    iss_en = 2'b11; iss_addr = {5'd7, 5'd7}; rd_addr = {5'd0, 5'd0, 5'd0, 5'd7};
    step(); idle();
    #1;
    checks++;
    if (rd_busy[0] !== 1'b1 || rd_busy_nb[0] !== 1'b1) begin
      errors++; $display("FAIL sb_issue2_busy: got %b/%b, need 1", rd_busy[0], rd_busy_nb[0]);
    end
    wr_en = 2'b01; wr_addr[0] = 5'd7; wr_data[0] = 32'hAAAA_0001;
    #1;
    checks++;
    if (rd_busy[0] !== 1'b1) begin
      errors++; $display("FAIL sb_retire1_busy: got %b, need 1", rd_busy[0]);
    end
    step(); idle();
    wr_en = 2'b10; wr_addr[1] = 5'd7; wr_data[1] = 32'hBBBB_0002;
    #1;
    checks++;
    if (rd_busy[0] !== 1'b0 || rd_data[0] !== 32'hBBBB_0002) begin
      errors++; $display("FAIL sb_retire2_bypass: busy %b data %h, need 0 bbbb0002", rd_busy[0], rd_data[0]);
    end
    checks++;
    if (rd_busy_nb[0] !== 1'b1 || rd_data_nb[0] !== 32'hAAAA_0001) begin
      errors++; $display("FAIL sb_retire2_nobypass: busy %b data %h, need 1 aaaa0001", rd_busy_nb[0], rd_data_nb[0]);
    end
    step(); idle();
    #1;
    checks++;
    if (rd_busy[0] !== 1'b0 || rd_busy_nb[0] !== 1'b0 || sb_err !== 1'b0) begin
      errors++; $display("FAIL sb_drained: busy %b/%b err %b, need 0", rd_busy[0], rd_busy_nb[0], sb_err);
    end
  endtask

  task automatic test_iss_wr_same();
    iss_en = 2'b01; iss_addr[0] = 5'd9; rd_addr = {5'd0, 5'd0, 5'd0, 5'd9};
    step(); idle();
    iss_en = 2'b10; iss_addr[1] = 5'd9;
    wr_en = 2'b01; wr_addr[0] = 5'd9; wr_data[0] = 32'hCCCC_1234;
    #1;
    checks++;
    if (rd_busy[0] !== 1'b1 || rd_data[0] !== 32'hCCCC_1234) begin
      errors++; $display("FAIL same_cycle_bypass: busy %b data %h, need 1 cccc1234", rd_busy[0], rd_data[0]);
    end
    step(); idle();
    #1;
    checks++;
    if (rd_busy[0] !== 1'b1 || rd_busy_nb[0] !== 1'b1 || rd_data_nb[0] !== 32'hCCCC_1234) begin
      errors++; $display("FAIL same_cycle_after: busy %b/%b data %h, need 1 cccc1234", rd_busy[0], rd_busy_nb[0], rd_data_nb[0]);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    iss_en = 2'b11; iss_addr = {5'd4, 5'd4}; rd_addr = {5'd0, 5'd0, 5'd6, 5'd4};
    step();
    #1;
    checks++;
    if (sb_err !== 1'b0 || rd_busy[0] !== 1'b1) begin
      errors++; $display("FAIL sat_first: err %b busy %b, need 0 1", sb_err, rd_busy[0]);
    end
    step(); idle();
    #1;
    checks++;
    if (sb_err !== 1'b1 || sb_err_nb !== 1'b1) begin
      errors++; $display("FAIL sat_overflow_err: got %b/%b, need 1", sb_err, sb_err_nb);
    end
    wr_en = 2'b11; wr_addr = {5'd4, 5'd4};
    step(); idle();
    #1;
    checks++;
    if (rd_busy[0] !== 1'b1 || rd_busy_nb[0] !== 1'b1) begin
      errors++; $display("FAIL sat_held_at_max: busy %b/%b, need 1", rd_busy[0], rd_busy_nb[0]);
    end
    flush = 1'b1; iss_en = 2'b01; iss_addr[0] = 5'd6;
    step(); idle();
    #1;
    checks++;
    if (rd_busy[0] !== 1'b0 || rd_busy[1] !== 1'b0 || rd_busy_nb[0] !== 1'b0 || rd_busy_nb[1] !== 1'b0) begin
      errors++; $display("FAIL flush_busy: got %b%b/%b%b, need 0", rd_busy[1], rd_busy[0], rd_busy_nb[1], rd_busy_nb[0]);
    end
    checks++;
    if (sb_err !== 1'b1) begin
      errors++; $display("FAIL flush_keeps_err: got %b, need 1", sb_err);
    end
    do_reset();
    #1;
    checks++;
    if (sb_err !== 1'b0 || sb_err_nb !== 1'b0) begin
      errors++; $display("FAIL rst_clears_err: got %b/%b, need 0", sb_err, sb_err_nb);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst   = ($urandom_range(0, 63) == 0);
      flush = ($urandom_range(0, 15) == 0);
      for (int w = 0; w < 2; w++) begin
        wr_en[w]    = $urandom_range(0, 2) == 0;
        wr_addr[w]  = 5'($urandom_range(0, 7));
        wr_data[w]  = $urandom;
        iss_en[w]   = $urandom_range(0, 2) == 0;
        iss_addr[w] = 5'($urandom_range(0, 7));
      end
      for (int p = 0; p < 4; p++)
        rd_addr[p] = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      #1;
      for (int p = 0; p < 4; p++) begin
        checks++;
        if (rd_data[p] !== exp_data(rd_addr[p], 1'b1) || rd_busy[p] !== exp_busy(rd_addr[p], 1'b1)) begin
          errors++;
          $display("FAIL rand_bypass c%0d p%0d r%0d: data %h busy %b, need %h %b", c, p, rd_addr[p],
                   rd_data[p], rd_busy[p], exp_data(rd_addr[p], 1'b1), exp_busy(rd_addr[p], 1'b1));
        end
        checks++;
        if (rd_data_nb[p] !== exp_data(rd_addr[p], 1'b0) || rd_busy_nb[p] !== exp_busy(rd_addr[p], 1'b0)) begin
          errors++;
          $display("FAIL rand_nobypass c%0d p%0d r%0d: data %h busy %b, need %h %b", c, p, rd_addr[p],
                   rd_data_nb[p], rd_busy_nb[p], exp_data(rd_addr[p], 1'b0), exp_busy(rd_addr[p], 1'b0));
        end
      end
      checks++;
      if (sb_err !== m_err || sb_err_nb !== m_err) begin
        errors++; $display("FAIL rand_sb_err c%0d: got %b/%b, need %b", c, sb_err, sb_err_nb, m_err);
      end
      step();
    end
    rst = 1'b0; idle();
  endtask

  initial begin
    rst = 1'b1; idle(); rd_addr = '0;
    step();
    test_reset();
    test_priority();
    test_zero();
    test_scoreboard();
    test_iss_wr_same();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
